// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and phase helpers for the CORDIC phase front end.
package cordic_pkg;

  localparam int CORDIC_PW     = 16;
  localparam int CORDIC_WL     = 16;
  localparam int CORDIC_FL     = 14;
  localparam int PI_OVER_2_Q14 = 25736;
  localparam int QUARTER_TURN  = 1 << (CORDIC_PW - 2);
  localparam int HALF_TURN     = 1 << (CORDIC_PW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  function automatic int quarter_of(input int pw);
    return 1 << (pw - 2);
  endfunction

  function automatic int half_of(input int pw);
    return 1 << (pw - 1);
  endfunction

endpackage

// File: rtl/cordic_phase_fold.sv
// Folds a full-turn phase into [-pi/2, pi/2] and converts it to Q1.14 radians.
// The fold is registered on load; the multiply/round lands one cycle later.
module cordic_phase_fold
  import cordic_pkg::*;
#(
  parameter int PW = CORDIC_PW,
  parameter int WL = CORDIC_WL,
  parameter int FL = CORDIC_FL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PW-1:0]        phase_i,
  input  logic                 load_i,
  output logic signed [WL-1:0] angle_o,
  output logic                 neg_cos_o
);

  localparam int PWX = PW + 1;
  localparam int PRW = PW + WL + 1;
  localparam logic signed [PW:0]    QTR = PWX'(quarter_of(PW));
  localparam logic signed [PW:0]    HLF = PWX'(half_of(PW));
  localparam logic signed [PRW-1:0] K   = PRW'(PI_OVER_2_Q14);
  localparam logic signed [PRW-1:0] RND = PRW'(1 << (FL - 1));

  logic signed [PW:0]    s_ext, p_d, p_q;
  logic                  neg_d, neg_q, calc_q;
  logic signed [PRW-1:0] prod, rnd;
  logic signed [WL-1:0]  angle_d, angle_q;
  logic                  unused_bits;

  always_comb begin
    s_ext = {phase_i[PW-1], phase_i};
    p_d   = s_ext;
    neg_d = 1'b0;
    if (s_ext > QTR) begin
      p_d   = HLF - s_ext;
      neg_d = 1'b1;
    end else if (s_ext < -QTR) begin
      p_d   = -HLF - s_ext;
      neg_d = 1'b1;
    end
  end

  // Low PRW bits of the two's complement product are sign-agnostic; the slice is a floor shift.
  always_comb begin
    prod    = {{WL{p_q[PW]}}, p_q} * K;
    rnd     = prod + RND;
    angle_d = rnd[FL+WL-1:FL];
  end

  assign unused_bits = ^{rnd[PRW-1:FL+WL], rnd[FL-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      neg_q   <= 1'b0;
      calc_q  <= 1'b0;
      angle_q <= '0;
    end else begin
      calc_q <= load_i;
      if (load_i) begin
        p_q   <= p_d;
        neg_q <= neg_d;
      end
      if (calc_q) angle_q <= angle_d;
    end
  end

  assign angle_o   = angle_q;
  assign neg_cos_o = neg_q;

endmodule

// File: rtl/cordic_phase_front.sv
// Control front end for the iterative CORDIC rotator: fold, start, wait, sign-correct, hand off.
// Optional watchdog on the rotator's done pulse is enabled with `define CORDIC_TIMEOUT_EN.
module cordic_phase_front
  import cordic_pkg::*;
#(
  parameter int PW          = CORDIC_PW,
  parameter int WL          = CORDIC_WL,
  parameter int FL          = CORDIC_FL,
  parameter int TIMEOUT_CYC = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_phase,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] out_cos,
  output logic signed [WL-1:0] out_sin,
  output logic                 cordic_start,
  output logic signed [WL-1:0] cordic_angle,
  input  logic signed [WL-1:0] cordic_cos,
  input  logic signed [WL-1:0] cordic_sin,
  input  logic                 cordic_done,
  output logic                 err
);

  localparam logic signed [WL-1:0] WMIN = {1'b1, {(WL-1){1'b0}}};
  localparam logic signed [WL-1:0] WMAX = ~WMIN;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q;
  logic                 in_ready_q, out_valid_q, start_q;
  logic signed [WL-1:0] cos_q, sin_q, cos_fix;
  logic                 neg_cos, load;

`ifdef CORDIC_TIMEOUT_EN
  logic [TW-1:0] tmr_q;
  logic          err_q;
`else
  logic [TW-1:0] unused_tmo;
  assign unused_tmo = TW'(TIMEOUT_CYC);
`endif

  assign load = in_valid & in_ready_q;

  cordic_phase_fold #(
    .PW (PW),
    .WL (WL),
    .FL (FL)
  ) u_fold (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_i   (in_phase),
    .load_i    (load),
    .angle_o   (cordic_angle),
    .neg_cos_o (neg_cos)
  );

  // Negating the most negative word would wrap, so it clamps to the most positive.
  always_comb begin
    cos_fix = cordic_cos;
    if (neg_cos) cos_fix = (cordic_cos == WMIN) ? WMAX : -cordic_cos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
`ifdef CORDIC_TIMEOUT_EN
      tmr_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (load) begin
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end
        S_PREP: begin
          start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
`ifdef CORDIC_TIMEOUT_EN
          tmr_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cordic_done) begin
            cos_q       <= cos_fix;
            sin_q       <= cordic_sin;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
`ifdef CORDIC_TIMEOUT_EN
          else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign cordic_start = start_q;
  assign out_cos      = cos_q;
  assign out_sin      = sin_q;
`ifdef CORDIC_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_phase_front.sv
// Scoreboard bench for cordic_phase_front with a behavioural rotator model.
module tb_cordic_phase_front;

  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        in_phase = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_cos, out_sin;
  logic               cordic_start;
  logic signed [15:0] cordic_angle;
  logic signed [15:0] cordic_cos = '0;
  logic signed [15:0] cordic_sin = '0;
  logic               cordic_done = 1'b0;
  logic               err;

  cordic_phase_front dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_phase     (in_phase),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cos      (out_cos),
    .out_sin      (out_sin),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .cordic_done  (cordic_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int phase;
    int ang;
    int ec;
    int es;
    int tol;
    bit chk_lat;
    int acc_cyc;
    int start_cyc;
    int starts;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Per-transaction settings shared by driver, rotator model and monitor.
  bit          cur_exact = 0;
  int          cur_ec = 0, cur_es = 0;
  bit          cur_chk_lat = 0;
  int          rot_lat = 17;
  bit          rot_hold = 0;
  bit          rot_ovr = 0;
  int          rot_c = 0, rot_s = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int req, input int tol);
    int d;
    checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/-%0d (cycle %0d)", nm, act, req, tol, cyc);
    end
  endtask

  // Reference: fold the phase by quadrant, scale to Q1.14 radians, and use exact trig for the result.
  function automatic int model_angle(input int ph);
    int s, p;
    longint prod;
    s = (ph >= 32768) ? ph - 65536 : ph;
    if (s > 16384)       p = 32768 - s;
    else if (s < -16384) p = -32768 - s;
    else                 p = s;
    prod = longint'(p) * 25736 + 8192;
    return int'(prod >>> 14);
  endfunction

  function automatic exp_t make_exp(input int ph);
    exp_t e;
    real th;
    th = 2.0 * PI * real'(ph) / 65536.0;
    e.phase     = ph;
    e.ang       = model_angle(ph);
    e.ec        = int'(16384.0 * $cos(th));
    e.es        = int'(16384.0 * $sin(th));
    e.tol       = 8;
    e.chk_lat   = cur_chk_lat;
    e.acc_cyc   = cyc;
    e.start_cyc = 0;
    e.starts    = 0;
    if (cur_exact) begin
      e.ec  = cur_ec;
      e.es  = cur_es;
      e.tol = 0;
    end
    return e;
  endfunction

  // Rotator model: answers each start with the Q1.14 cos/sin of the presented angle.
  int rot_a, rot_l;
  initial forever begin
    @(negedge clk);
    if (rst_n && cordic_start && !rot_hold) begin
      rot_a = cordic_angle;
      rot_l = (rot_lat < 1) ? 1 : rot_lat;
      repeat (rot_l) @(posedge clk);
      #1;
      if (rot_ovr) begin
        cordic_cos = 16'(rot_c);
        cordic_sin = 16'(rot_s);
      end else begin
        cordic_cos = 16'(int'(16384.0 * $cos(real'(rot_a) / 16384.0)));
        cordic_sin = 16'(int'(16384.0 * $sin(real'(rot_a) / 16384.0)));
      end
      cordic_done = 1'b1;
      @(posedge clk);
      #1 cordic_done = 1'b0;
    end
  end

  // Monitor: owns the scoreboard, pushes on acceptance, checks start/angle, hold and results.
  bit                 prev_ov = 0, prev_or = 0;
  logic signed [15:0] prev_cos = '0, prev_sin = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      prev_ov = 0;
      prev_or = 0;
      continue;
    end
`ifdef CORDIC_TIMEOUT_EN
    if (err) begin
      if (sb.size() == 0) begin
        chk("err_without_request", sb.size(), 1);
      end else begin
        chk("timeout_cycle", cyc - sb[0].start_cyc, 32);
        chk("timeout_in_ready", in_ready, 1);
        chk("timeout_out_valid", out_valid, 0);
        void'(sb.pop_front());
      end
    end
`else
    chk("err_tied_low", err, 0);
`endif
    if (in_ready) chk("in_ready_while_busy", sb.size(), 0);
    if (in_valid && in_ready) sb.push_back(make_exp(in_phase));
    if (cordic_start) begin
      if (sb.size() == 0) begin
        chk("spurious_start", 1, 0);
      end else begin
        e = sb[0];
        e.starts++;
        e.start_cyc = cyc;
        chk("single_start", e.starts, 1);
        chk("cordic_angle", cordic_angle, e.ang);
        if (e.chk_lat) chk("start_latency", cyc - e.acc_cyc, 2);
        sb[0] = e;
      end
    end
    if (prev_ov && !prev_or) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_cos", out_cos, prev_cos);
      chk("hold_out_sin", out_sin, prev_sin);
      chk("hold_in_ready", in_ready, 0);
    end
    if (out_valid && !prev_ov && sb.size() != 0 && sb[0].chk_lat)
      chk("out_latency", cyc - sb[0].acc_cyc, 20);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk_tol($sformatf("out_cos ph=%04h", e.phase), out_cos, e.ec, e.tol);
        chk_tol($sformatf("out_sin ph=%04h", e.phase), out_sin, e.es, e.tol);
      end
    end
    prev_ov  = out_valid;
    prev_or  = out_ready;
    prev_cos = out_cos;
    prev_sin = out_sin;
  end

  // Called at posedge+1; returns at posedge+1 after the result handshake.
  task automatic txn(input logic [15:0] ph, input int lat, input int stall, input bit lat_chk,
                     input bit keep, input logic [15:0] next_ph,
                     input bit exact, input int rc, input int rs, input int ec, input int es);
    bit ok;
    cur_exact   = exact;
    cur_ec      = ec;
    cur_es      = es;
    cur_chk_lat = lat_chk;
    rot_lat     = lat;
    rot_ovr     = exact;
    rot_c       = rc;
    rot_s       = rs;
    in_phase    = ph;
    in_valid    = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_in_time", ok, 1);
    @(posedge clk);
    #1;
    if (keep) in_phase = next_ph;
    else      in_valid = 1'b0;
    if (stall == 0) out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("out_valid_in_time", ok, 1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_cordic_start"}, cordic_start, 0);
    chk({tag, "_cordic_angle"}, cordic_angle, 0);
    chk({tag, "_out_cos"}, out_cos, 0);
    chk({tag, "_out_sin"}, out_sin, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ph_cur, ph_nxt;
    bit ok;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed quadrant and boundary phases; first one also checks the 20-cycle latency.
    txn(16'h0000, 17, 0, 1, 0, 16'h0, 0, 0, 0, 0, 0);
    txn(16'h2000, 9, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    txn(16'hA000, 5, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    txn(16'h4000, 4, 2, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    txn(16'hC000, 3, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    txn(16'h8000, 6, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);

    // Back-to-back with a 10-cycle consumer stall; the second request waits for the handshake.
    txn(16'h2000, 7, 10, 0, 1, 16'h6000, 0, 0, 0, 0, 0);
    txn(16'h6000, 7, 10, 0, 0, 16'h0, 0, 0, 0, 0, 0);

    // Saturating negation on a folded phase, and no negation on an unfolded one.
    txn(16'h8000, 5, 1, 0, 0, 16'h0, 1, -32768, 7, 32767, 7);
    txn(16'h1000, 5, 0, 0, 0, 16'h0, 1, -32768, -5, -32768, -5);

    ph_cur = 16'($urandom);
    for (int i = 0; i < 30; i++) begin
      bit keep_v;
      ph_nxt = 16'($urandom);
      keep_v = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      txn(ph_cur, int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), 0, keep_v, ph_nxt,
          0, 0, 0, 0, 0);
      ph_cur = ph_nxt;
    end

    // Rotator withholds done.
    rot_hold    = 1;
    cur_exact   = 1;
    cur_ec      = -1234;
    cur_es      = -99;
    cur_chk_lat = 0;
    in_phase    = 16'h7000;
    in_valid    = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("hold_accept", ok, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef CORDIC_TIMEOUT_EN
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err) begin ok = 1; break; end
    end
    chk("timeout_err_seen", ok, 1);
    @(posedge clk);
    #1;
`else
    repeat (40) @(negedge clk);
    chk("withheld_no_out_valid", out_valid, 0);
    chk("withheld_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cordic_cos  = 16'sd1234;
    cordic_sin  = -16'sd99;
    cordic_done = 1'b1;
    @(posedge clk);
    #1;
    cordic_done = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    chk("late_done_out_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
`endif

    // Reset during WAIT, then a stray done while idle.
    cur_exact = 0;
    in_phase  = 16'h2000;
    in_valid  = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("rst_accept", ok, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cordic_cos  = 16'sd500;
    cordic_sin  = 16'sd600;
    cordic_done = 1'b1;
    @(posedge clk);
    #1 cordic_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stray_done_out_valid", out_valid, 0);
      chk("stray_done_in_ready", in_ready, 1);
    end
    rot_hold = 0;
    @(posedge clk);
    #1;
    txn(16'hE000, 8, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
